coo_stream_fetcher: RTL



---
 rtl/smvm_pkg.sv | 23 ++
 rtl/coo_stream_fetcher_if.sv | 36 +++
 rtl/coo_channel_ptr.sv | 48 ++++
 rtl/coo_stream_fetcher.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/smvm_pkg.sv
// Shared definitions for the COO stream fetcher.
//   fetch_state_t : controller states (IDLE, FETCH, DRAIN, DONE)
//   DRAIN_CYCLES  : cycles spent flushing the issue->beat pipeline
//   sentinel_row  : row id used to mark padded/exhausted lanes
package smvm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fetch_state_t;

    // The last issued read needs two more cycles (memory + beat register).
    localparam int DRAIN_CYCLES = 2;

    // The sentinel row id equals the matrix row count, so downstream can
    // skip such lanes with a single compare.
    function automatic logic [31:0] sentinel_row(input int unsigned num_rows);
        return 32'(num_rows);
    endfunction

endpackage

// File: rtl/coo_stream_fetcher_if.sv
// Bus bundle for coo_stream_fetcher.
//   control : start, hold, ch_base, ch_count (into the fetcher)
//   memory  : mem_rd, mem_addr (out), mem_value/mem_col/mem_row (in, one
//             cycle after mem_rd)
//   beat    : values, col_id, row_id, rdy (out), plus busy/done status
// master = fetcher side, slave = environment side.
interface coo_stream_fetcher_if #(
    parameter int NUM_CHANNELS = 4,
    parameter int ADDR_W       = 10
);
    logic                                  start;
    logic                                  hold;
    logic [NUM_CHANNELS-1:0][ADDR_W-1:0]   ch_base;
    logic [NUM_CHANNELS-1:0][ADDR_W:0]     ch_count;
    logic [NUM_CHANNELS-1:0]               mem_rd;
    logic [NUM_CHANNELS-1:0][ADDR_W-1:0]   mem_addr;
    logic [NUM_CHANNELS-1:0][31:0]         mem_value;
    logic [NUM_CHANNELS-1:0][31:0]         mem_col;
    logic [NUM_CHANNELS-1:0][31:0]         mem_row;
    logic [NUM_CHANNELS-1:0][31:0]         values;
    logic [NUM_CHANNELS-1:0][31:0]         col_id;
    logic [NUM_CHANNELS-1:0][31:0]         row_id;
    logic                                  rdy;
    logic                                  busy;
    logic                                  done;

    modport master (
        input  start, hold, ch_base, ch_count, mem_value, mem_col, mem_row,
        output mem_rd, mem_addr, values, col_id, row_id, rdy, busy, done
    );

    modport slave (
        output start, hold, ch_base, ch_count, mem_value, mem_col, mem_row,
        input  mem_rd, mem_addr, values, col_id, row_id, rdy, busy, done
    );
endinterface

// File: rtl/coo_channel_ptr.sv
// Per-channel COO walk state: read pointer and remaining-entry count.
//   load           : capture base/count (accepted start)
//   issue_en       : controller allows reads this cycle (FETCH, no hold)
//   issue          : this channel reads this cycle
//   addr           : read address (zero when not issuing)
//   exhausted_next : no entries left after this cycle's update
module coo_channel_ptr #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   count,
    output logic              issue,
    output logic [ADDR_W-1:0] addr,
    output logic              exhausted_next
);
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   rem_q, rem_d;

    always_comb begin
        ptr_d = ptr_q;
        rem_d = rem_q;
        issue = issue_en && (rem_q != '0);
        if (load) begin
            ptr_d = base;
            rem_d = count;
        end else if (issue) begin
            // Pointer wraps naturally at 2^ADDR_W.
            ptr_d = ptr_q + ADDR_W'(1);
            rem_d = rem_q - (ADDR_W+1)'(1);
        end
        addr           = issue ? ptr_q : '0;
        exhausted_next = (rem_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            rem_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            rem_q <= rem_d;
        end
    end
endmodule

// File: rtl/coo_stream_fetcher.sv
// COO stream fetcher: walks NUM_CHANNELS slices of a COO matrix and emits
// one (value, col_id, row_id) triple per channel per beat, qualified by rdy.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : coo_stream_fetcher_if.master (control, memory, beat, status)
// Issue in cycle t -> memory data in t+1 -> registered beat in t+2.
module coo_stream_fetcher
    import smvm_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int NUM_ROWS     = 128,
    parameter int ADDR_W       = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    coo_stream_fetcher_if.master  bus
);
    localparam logic [31:0] SENTINEL_ROW = sentinel_row(NUM_ROWS);
    localparam logic [1:0]  DRAIN_LAST   = 2'(DRAIN_CYCLES - 1);

    fetch_state_t state_q, state_d;
    logic [1:0]   drain_cnt_q, drain_cnt_d;
    logic         load, issue_en;

    wire  [NUM_CHANNELS-1:0] issue;
    wire  [NUM_CHANNELS-1:0] exhausted_next;
    wire  [NUM_CHANNELS-1:0] count_zero;
    logic [ADDR_W-1:0]       addr_arr [NUM_CHANNELS];

    // Stage 1: which lanes issued last cycle (their data is on mem_* now).
    logic [NUM_CHANNELS-1:0] issued_q, issued_d;
    logic                    rdy_q, rdy_d;
    logic                    beat_valid;

    // Stage 2: beat output registers.
    logic [31:0] val_q [NUM_CHANNELS];
    logic [31:0] val_d [NUM_CHANNELS];
    logic [31:0] col_q [NUM_CHANNELS];
    logic [31:0] col_d [NUM_CHANNELS];
    logic [31:0] row_q [NUM_CHANNELS];
    logic [31:0] row_d [NUM_CHANNELS];

    assign beat_valid = |issued_q;

    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_lane
        coo_channel_ptr #(.ADDR_W(ADDR_W)) u_ptr (
            .clk            (clk),
            .rst            (rst),
            .load           (load),
            .issue_en       (issue_en),
            .base           (bus.ch_base[gi]),
            .count          (bus.ch_count[gi]),
            .issue          (issue[gi]),
            .addr           (addr_arr[gi]),
            .exhausted_next (exhausted_next[gi])
        );

        assign count_zero[gi] = (bus.ch_count[gi] == '0);

        always_comb begin
            val_d[gi] = val_q[gi];
            col_d[gi] = col_q[gi];
            row_d[gi] = row_q[gi];
            if (beat_valid) begin
                if (issued_q[gi]) begin
                    val_d[gi] = bus.mem_value[gi];
                    col_d[gi] = bus.mem_col[gi];
                    row_d[gi] = bus.mem_row[gi];
                end else begin
                    // Exhausted lane inside a live beat: padded entry.
                    val_d[gi] = '0;
                    col_d[gi] = '0;
                    row_d[gi] = SENTINEL_ROW;
                end
            end
            // Entering/holding DONE: every lane shows the completion marker.
            // The pipeline is empty by then, so this never hides a beat.
            if (state_d == DONE) begin
                row_d[gi] = SENTINEL_ROW;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                val_q[gi] <= '0;
                col_q[gi] <= '0;
                row_q[gi] <= '0;
            end else begin
                val_q[gi] <= val_d[gi];
                col_q[gi] <= col_d[gi];
                row_q[gi] <= row_d[gi];
            end
        end
    end

    // Controller next state.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        load        = 1'b0;
        issue_en    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    load        = 1'b1;
                    drain_cnt_d = '0;
                    state_d     = (&count_zero) ? DRAIN : FETCH;
                end
            end
            FETCH: begin
                issue_en = !bus.hold;
                if (&exhausted_next) begin
                    drain_cnt_d = '0;
                    state_d     = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        issued_d = issue;
        rdy_d    = beat_valid;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            drain_cnt_q <= '0;
            issued_q    <= '0;
            rdy_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            issued_q    <= issued_d;
            rdy_q       <= rdy_d;
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            bus.mem_addr[k] = addr_arr[k];
            bus.values[k]   = val_q[k];
            bus.col_id[k]   = col_q[k];
            bus.row_id[k]   = row_q[k];
        end
    end

    assign bus.mem_rd = issue;
    assign bus.rdy    = rdy_q;
    assign bus.busy   = (state_q == FETCH) || (state_q == DRAIN);
    assign bus.done   = (state_q == DONE);
endmodule
